seq_arb_4in_rr_lock: RTL and testbench

Four-input sequential round-robin arbiter with registered one-hot grants and lockable multi-cycle tenure. It shares one downstream resource, such as a bus, memory port or functional unit, among four requesters. A requester may hold the resource across consecutive cycles by asserting its lock, and fairness advances the priority pointer past each new winner. An optional tenure limit forces a locked owner to yield to waiting requesters.

---
 rtl/seq_arb_4in_rr_lock.sv | 123 ++++++++++++
 tb/tb_seq_arb_4in_rr_lock.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_arb_4in_rr_lock.sv
// ============================================================================
// Module   : seq_arb_4in_rr_lock
// Purpose  : 4-input round-robin arbiter, registered one-hot grants, lockable
//            tenure; optional tenure limit via SEQ_ARB_RR_LOCK_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_arb_4in_rr_lock #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] reqs,
  input  logic [3:0] locks,
  output logic [3:0] grants,
  output logic [1:0] grant_id,
  output logic       grant_held
);

  logic [3:0] grants_q, grants_d;
  logic [3:0] prio_q, prio_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic       grant_held_q, grant_held_d;
  logic       expire;
  logic       keep;
  logic [3:0] cand;
  logic [3:0] pick;
  logic [1:0] pidx;
  logic [1:0] idx;
  logic       found;

`ifdef SEQ_ARB_RR_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  assign expire = (hold_cnt_q == CW'(HOLD_MAX));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (keep) begin
      if (hold_cnt_q != CW'(HOLD_MAX)) hold_cnt_d = hold_cnt_q + 1'b1;
    end else begin
      hold_cnt_d = (pick != 4'b0000) ? CW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  assign keep = (|(reqs & grants_q)) & (|(locks & grants_q)) & ~expire;

  // Expired owner steps aside only if somebody else is actually waiting.
  always_comb begin
    cand = reqs;
    if (expire && ((reqs & ~grants_q) != 4'b0000)) cand = reqs & ~grants_q;
  end

  always_comb begin
    pidx = 2'd0;
    if (prio_q[1]) pidx = 2'd1;
    if (prio_q[2]) pidx = 2'd2;
    if (prio_q[3]) pidx = 2'd3;
  end

  always_comb begin
    pick  = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = pidx + 2'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = 4'b0001 << idx;
      end
    end
  end

  always_comb begin
    grants_d     = grants_q;
    prio_d       = prio_q;
    grant_held_d = 1'b0;
    if (keep) begin
      grant_held_d = 1'b1;
    end else begin
      grants_d = pick;
      if (pick != 4'b0000) prio_d = {pick[2:0], pick[3]};
    end
  end

  always_comb begin
    grant_id_d = 2'd0;
    if (grants_d[1]) grant_id_d = 2'd1;
    if (grants_d[2]) grant_id_d = 2'd2;
    if (grants_d[3]) grant_id_d = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grants_q     <= 4'b0000;
      prio_q       <= 4'b0001;
      grant_id_q   <= 2'd0;
      grant_held_q <= 1'b0;
    end else begin
      grants_q     <= grants_d;
      prio_q       <= prio_d;
      grant_id_q   <= grant_id_d;
      grant_held_q <= grant_held_d;
    end
  end

  assign grants     = grants_q;
  assign grant_id   = grant_id_q;
  assign grant_held = grant_held_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_arb_4in_rr_lock.sv
// ============================================================================
// Module   : tb_seq_arb_4in_rr_lock
// Purpose  : Directed self-checking bench for seq_arb_4in_rr_lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_arb_4in_rr_lock;

`ifdef SEQ_ARB_RR_LOCK_TIMEOUT_EN
  localparam int HM       = 4;
  localparam int LOCK_CYC = 4;
`else
  localparam int HM       = 8;
  localparam int LOCK_CYC = 5;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] reqs;
  logic [3:0] locks;
  logic [3:0] grants;
  logic [1:0] grant_id;
  logic       grant_held;

  int n_cmp = 0;
  int n_err = 0;

  seq_arb_4in_rr_lock #(.HOLD_MAX(HM)) dut (
    .clk        (clk),
    .reset      (reset),
    .reqs       (reqs),
    .locks      (locks),
    .grants     (grants),
    .grant_id   (grant_id),
    .grant_held (grant_held)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] lk);
    reset = r;
    reqs  = rq;
    locks = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic eh);
    n_cmp++;
    assert (grants === eg) else begin
      n_err++;
      $error("FAIL %s grants got %b exp %b", tag, grants, eg);
    end
    n_cmp++;
    assert (grant_id === id_of(eg)) else begin
      n_err++;
      $error("FAIL %s grant_id got %0d exp %0d", tag, grant_id, id_of(eg));
    end
    n_cmp++;
    assert (grant_held === eh) else begin
      n_err++;
      $error("FAIL %s grant_held got %b exp %b", tag, grant_held, eh);
    end
  endtask

  logic [3:0] rot_exp [5];
  logic [3:0] sp_exp  [4];
  logic [3:0] to_exp  [9];
  logic       toh_exp [9];

  initial begin
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sp_exp  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`ifdef SEQ_ARB_RR_LOCK_TIMEOUT_EN
    to_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    toh_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    to_exp  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    toh_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset with everything requesting and locking
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 4'b1111, 4'b1111);
      chk("reset", 4'b0000, 1'b0);
    end

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'b1111, 4'b0000);
      chk($sformatf("rot%0d", i), rot_exp[i], 1'b0);
    end

    cyc(1'b1, 4'b0000, 4'b0000);
    chk("rst_sp", 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'b0101, 4'b0000);
      chk($sformatf("sparse%0d", i), sp_exp[i], 1'b0);
    end
    cyc(1'b0, 4'b0000, 4'b0000);
    chk("idle", 4'b0000, 1'b0);

    // prio now 1000 -> requester 0 wins first
    for (int i = 0; i < LOCK_CYC; i++) begin
      cyc(1'b0, 4'b0011, 4'b0001);
      chk($sformatf("lock%0d", i), 4'b0001, (i != 0));
    end
    cyc(1'b0, 4'b0011, 4'b0000);
    chk("unlock", 4'b0010, 1'b0);

    cyc(1'b1, 4'b0000, 4'b0000);
    chk("rst_to", 4'b0000, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 4'b0011, 4'b0011);
      chk($sformatf("tmo%0d", i), to_exp[i], toh_exp[i]);
    end

`ifdef SEQ_ARB_RR_LOCK_TIMEOUT_EN
    cyc(1'b1, 4'b0000, 4'b0000);
    chk("rst_sole", 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'b0001, 4'b0001);
      chk($sformatf("sole%0d", i), 4'b0001, (i != 0 && i != 4));
    end
`endif

    cyc(1'b1, 4'b0000, 4'b0000);
    chk("rst_mh", 4'b0000, 1'b0);
    cyc(1'b0, 4'b1000, 4'b1000);
    chk("mh_win", 4'b1000, 1'b0);
    cyc(1'b0, 4'b1000, 4'b1000);
    chk("mh_hold", 4'b1000, 1'b1);
    cyc(1'b1, 4'b1000, 4'b1000);
    chk("mh_reset", 4'b0000, 1'b0);
    cyc(1'b0, 4'b1010, 4'b0000);
    chk("mh_after", 4'b0010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
